sonar_driver: RTL and testbench

Responder side of the control unit's measure handshake: accepts a one-cycle `measure` request, fires the ultrasonic ranger's trigger pulse, times the returned echo and presents an 8-bit distance with a `ready` level. Sits between the control unit (`sonar_measure` → `measure`, `sonar_ready` ← `ready`, `sonar_distance` ← `distance`) and the ranger pins (`trig`, `echo`).

---
 rtl/sonar_driver_if.sv | 15 +
 rtl/sonar_driver.sv | 146 ++++++++++++++
 tb/tb_sonar_driver.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sonar_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : sonar_driver_if
// Brief    : Measure request / result handshake between control unit and ranger driver.
// Revision : 1.0
// ============================================================================
interface sonar_driver_if;
    logic       measure;
    logic       ready;
    logic [7:0] distance;

    modport master (output measure, input ready, input distance);
    modport slave  (input measure, output ready, output distance);
endinterface
`default_nettype wire

// File: rtl/sonar_driver.sv
`default_nettype none
// ============================================================================
// Module   : sonar_driver
// Brief    : Fires the ultrasonic trigger on request, times the echo and
//            reports an 8-bit saturating distance with a ready level.
// Revision : 1.0
// ============================================================================
module sonar_driver #(
    parameter int TRIG_CYCLES     = 500,
    parameter int CYCLES_PER_UNIT = 2900,
    parameter int ECHO_TIMEOUT    = 1_500_000,
    parameter int HOLDOFF_CYCLES  = 3_000_000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    sonar_driver_if.slave      bus,
    input  wire logic          echo,
    output logic               trig
);

    localparam int c_MAX_A   = (ECHO_TIMEOUT > HOLDOFF_CYCLES) ? ECHO_TIMEOUT : HOLDOFF_CYCLES;
    localparam int c_CNT_MAX = (c_MAX_A > TRIG_CYCLES) ? c_MAX_A : TRIG_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_PRE_W   = $clog2(CYCLES_PER_UNIT + 1);

    localparam logic [c_CNT_W-1:0] c_TRIG_LAST = c_CNT_W'(TRIG_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ECHO_LAST = c_CNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST  = c_PRE_W'(CYCLES_PER_UNIT - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_TRIG      = 3'd1;
    localparam logic [2:0] c_WAIT_ECHO = 3'd2;
    localparam logic [2:0] c_COUNT     = 3'd3;
    localparam logic [2:0] c_HOLDOFF   = 3'd4;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_PRE_W-1:0] r_pre;
    logic [7:0]         r_acc;
    logic [7:0]         r_distance;
    logic               r_ready;
    logic               r_trig;
    logic               r_echo_meta;
    logic               r_echo_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_echo_meta <= 1'b0;
            r_echo_s    <= 1'b0;
        end else begin
            r_echo_meta <= echo;
            r_echo_s    <= r_echo_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_pre      <= '0;
            r_acc      <= '0;
            r_distance <= '0;
            r_ready    <= 1'b1;
            r_trig     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.measure) begin
                        r_state <= c_TRIG;
                        r_cnt   <= '0;
                        r_pre   <= '0;
                        r_ready <= 1'b0;
                        r_trig  <= 1'b1;
                    end
                end
                c_TRIG: begin
                    if (r_cnt == c_TRIG_LAST) begin
                        r_state <= c_WAIT_ECHO;
                        r_cnt   <= '0;
                        r_trig  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_WAIT_ECHO: begin
                    if (r_echo_s) begin
                        r_state <= c_COUNT;
                        r_cnt   <= '0;
                        r_pre   <= '0;
                        r_acc   <= '0;
                    end else if (r_cnt == c_ECHO_LAST) begin
                        r_state    <= c_HOLDOFF;
                        r_cnt      <= '0;
                        r_distance <= 8'hFF;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_COUNT: begin
                    // Partial unit at echo fall is dropped: only completed prescaler wraps count.
                    if (!r_echo_s) begin
                        r_state    <= c_HOLDOFF;
                        r_cnt      <= '0;
                        r_distance <= r_acc;
                    end else if (r_cnt == c_ECHO_LAST) begin
                        r_state    <= c_HOLDOFF;
                        r_cnt      <= '0;
                        r_distance <= 8'hFF;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        if (r_pre == c_PRE_LAST) begin
                            r_pre <= '0;
                            if (r_acc != 8'hFF) begin
                                r_acc <= r_acc + 8'd1;
                            end
                        end else begin
                            r_pre <= r_pre + c_PRE_W'(1);
                        end
                    end
                end
                c_HOLDOFF: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                    r_trig  <= 1'b0;
                end
            endcase
        end
    end

    assign trig         = r_trig;
    assign bus.ready    = r_ready;
    assign bus.distance = r_distance;

endmodule
`default_nettype wire

// File: tb/tb_sonar_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonar_driver
// Brief    : Directed self-checking bench for sonar_driver.
// Revision : 1.0
// ============================================================================
module tb_sonar_driver;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic echo  = 1'b0;
    logic trig;
    int   n_chk      = 0;
    int   n_fail     = 0;
    int   trig_rises = 0;
    int   rises_before;

    sonar_driver_if bus ();

    sonar_driver #(
        .TRIG_CYCLES     (4),
        .CYCLES_PER_UNIT (10),
        .ECHO_TIMEOUT    (3000),
        .HOLDOFF_CYCLES  (20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .echo  (echo),
        .trig  (trig)
    );

    always #5 clk = ~clk;

    always @(posedge trig) trig_rises++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_measure();
        bus.measure = 1'b1;
        @(negedge clk);
        bus.measure = 1'b0;
        chk("ready_fall", bus.ready, 0);
        chk("trig_rise", trig, 1);
    endtask

    task automatic pulse_measure();
        bus.measure = 1'b1;
        @(negedge clk);
        bus.measure = 1'b0;
    endtask

    task automatic count_trig(input int exp);
        int n = 0;
        while (trig === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("trig_width", n, exp);
    endtask

    task automatic wait_ready(input int exp);
        int n = 0;
        while (bus.ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_delay", n, exp);
    endtask

    // Result lands on the third edge after the pin falls (two sync flops + FSM).
    task automatic echo_pulse(input int width, input logic [7:0] old_d, input logic [7:0] new_d);
        echo = 1'b1;
        repeat (width) @(negedge clk);
        echo = 1'b0;
        repeat (2) @(negedge clk);
        chk("dist_hold", bus.distance, old_d);
        @(negedge clk);
        chk("dist_new", bus.distance, new_d);
        chk("ready_low", bus.ready, 0);
        wait_ready(20);
    endtask

    initial begin
        bus.measure = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", bus.ready, 1);
        chk("rst_trig", trig, 0);
        chk("rst_dist", bus.distance, 0);

        // Nominal echo of 125 clocks, 50 clocks after trig falls
        start_measure();
        count_trig(4);
        repeat (50) @(negedge clk);
        echo_pulse(125, 8'd0, 8'd12);

        // Saturation, with ignored requests in TRIG, COUNT and HOLDOFF
        rises_before = trig_rises;
        start_measure();
        pulse_measure();
        count_trig(3);
        echo = 1'b1;
        repeat (1000) @(negedge clk);
        pulse_measure();
        repeat (1699) @(negedge clk);
        echo = 1'b0;
        repeat (2) @(negedge clk);
        chk("sat_hold", bus.distance, 12);
        @(negedge clk);
        chk("sat_dist", bus.distance, 8'hFF);
        pulse_measure();
        wait_ready(19);
        repeat (3) @(negedge clk);
        chk("ignored_ready", bus.ready, 1);
        chk("ignored_trig", trig, 0);
        chk("one_trig_pulse", trig_rises - rises_before, 1);

        start_measure();
        count_trig(4);
        echo_pulse(55, 8'hFF, 8'd5);

        // No echo: WAIT_ECHO timeout
        start_measure();
        count_trig(4);
        repeat (2999) @(negedge clk);
        chk("noecho_hold", bus.distance, 5);
        @(negedge clk);
        chk("noecho_dist", bus.distance, 8'hFF);
        wait_ready(20);

        start_measure();
        count_trig(4);
        echo_pulse(35, 8'hFF, 8'd3);

        // Echo stuck high: COUNT timeout
        start_measure();
        count_trig(4);
        echo = 1'b1;
        repeat (3002) @(negedge clk);
        chk("cnt_to_hold", bus.distance, 3);
        @(negedge clk);
        chk("cnt_to_dist", bus.distance, 8'hFF);
        wait_ready(20);
        echo = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during COUNT, then a fresh measurement
        start_measure();
        count_trig(4);
        echo = 1'b1;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        echo  = 1'b0;
        chk("mid_rst_trig", trig, 0);
        chk("mid_rst_ready", bus.ready, 1);
        chk("mid_rst_dist", bus.distance, 0);
        @(negedge clk);
        start_measure();
        count_trig(4);
        echo_pulse(75, 8'd0, 8'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
